d_mem_arbiter: RTL and testbench

D_MEM_ARBITER -- requirements
Module: d_mem_arbiter

---
 rtl/config_pkg.sv | 12 +
 rtl/d_mem_arbiter_if.sv | 61 ++++++
 rtl/d_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_d_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared data-memory configuration: address width and access-width encoding.
package config_pkg;

  localparam int unsigned DMemAddrWidth = 12;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALFWORD = 2'd1,
    MEM_WORD     = 2'd2
  } mem_width_t;

endpackage

// File: rtl/d_mem_arbiter_if.sv
// Bus bundle between the two requesters (cpu, dma), the arbiter and the
// single-port data memory.
//   cpu_*/dma_*  : request command, grant and load-return per requester
//   mem_*        : command to d_mem_spram and its extended load data
//   busy         : arbiter is holding a load for its return cycle
// slave  : arbiter view. master : requester/memory (environment) view.
interface d_mem_arbiter_if #(
  parameter int unsigned DMemAddrWidth = config_pkg::DMemAddrWidth
);
  import config_pkg::*;

  logic                     cpu_req;
  logic                     cpu_we;
  mem_width_t               cpu_width;
  logic                     cpu_sign_extend;
  logic [DMemAddrWidth-1:0] cpu_addr;
  logic [31:0]              cpu_wdata;
  logic                     cpu_gnt;
  logic                     cpu_rvalid;
  logic [31:0]              cpu_rdata;

  logic                     dma_req;
  logic                     dma_we;
  mem_width_t               dma_width;
  logic                     dma_sign_extend;
  logic [DMemAddrWidth-1:0] dma_addr;
  logic [31:0]              dma_wdata;
  logic                     dma_gnt;
  logic                     dma_rvalid;
  logic [31:0]              dma_rdata;

  mem_width_t               mem_width;
  logic                     mem_sign_extend;
  logic [DMemAddrWidth-1:0] mem_addr;
  logic [31:0]              mem_data_in;
  logic                     mem_write_enable;
  logic [31:0]              mem_data_out;

  logic                     busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_width, cpu_sign_extend, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_width, dma_sign_extend, dma_addr, dma_wdata,
    input  mem_data_out,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_width, mem_sign_extend, mem_addr, mem_data_in, mem_write_enable,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_width, cpu_sign_extend, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_width, dma_sign_extend, dma_addr, dma_wdata,
    output mem_data_out,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_width, mem_sign_extend, mem_addr, mem_data_in, mem_write_enable,
    input  busy
  );

endinterface

// File: rtl/d_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : asynchronous, active-low
//   arb_if : slave side of d_mem_arbiter_if (cpu/dma requests, mem command)
// Grants are combinational in IDLE. Stores finish in the grant cycle; loads
// latch their command and spend one RD_HOLD cycle returning memory data.
// cpu has priority, except that after MaxCoreStreak consecutive contested
// cpu grants the dma port wins once.
module d_mem_arbiter
  import config_pkg::*;
#(
  parameter int unsigned DMemAddrWidth = config_pkg::DMemAddrWidth,
  parameter int unsigned MaxCoreStreak = 4
) (
  input  logic           clk,
  input  logic           reset,
  d_mem_arbiter_if.slave arb_if
);

  localparam int unsigned StreakW = $clog2(MaxCoreStreak + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_HOLD = 1'b1;

  logic [0:0]               state_q,  state_d;
  logic [StreakW-1:0]       streak_q, streak_d;
  logic                     owner_q,  owner_d;   // 0 = cpu, 1 = dma
  logic [DMemAddrWidth-1:0] addr_q,   addr_d;
  mem_width_t               width_q,  width_d;
  logic                     sext_q,   sext_d;

  logic cpu_win;
  logic dma_win;

  // Arbitration, memory command steering and load return.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    width_d  = width_q;
    sext_d   = sext_q;
    cpu_win  = 1'b0;
    dma_win  = 1'b0;

    arb_if.cpu_gnt          = 1'b0;
    arb_if.dma_gnt          = 1'b0;
    arb_if.cpu_rvalid       = 1'b0;
    arb_if.dma_rvalid       = 1'b0;
    arb_if.cpu_rdata        = 32'h0;
    arb_if.dma_rdata        = 32'h0;
    arb_if.busy             = 1'b0;
    arb_if.mem_width        = arb_if.cpu_width;
    arb_if.mem_sign_extend  = arb_if.cpu_sign_extend;
    arb_if.mem_addr         = arb_if.cpu_addr;
    arb_if.mem_data_in      = arb_if.cpu_wdata;
    arb_if.mem_write_enable = 1'b0;

    // The streak only counts runs where dma is actually waiting.
    if (!arb_if.dma_req) streak_d = '0;

    // Reset is also applied here so grants drop the instant it asserts.
    if (reset) begin
      case (state_q)
        IDLE: begin
          cpu_win = arb_if.cpu_req &&
                    (!arb_if.dma_req || streak_q != StreakW'(MaxCoreStreak));
          dma_win = arb_if.dma_req && !cpu_win;

          if (cpu_win) begin
            arb_if.cpu_gnt          = 1'b1;
            arb_if.mem_write_enable = arb_if.cpu_we;
            if (arb_if.dma_req) streak_d = streak_q + StreakW'(1);
            if (!arb_if.cpu_we) begin
              state_d = RD_HOLD;
              owner_d = 1'b0;
              addr_d  = arb_if.cpu_addr;
              width_d = arb_if.cpu_width;
              sext_d  = arb_if.cpu_sign_extend;
            end
          end else if (dma_win) begin
            arb_if.dma_gnt          = 1'b1;
            arb_if.mem_width        = arb_if.dma_width;
            arb_if.mem_sign_extend  = arb_if.dma_sign_extend;
            arb_if.mem_addr         = arb_if.dma_addr;
            arb_if.mem_data_in      = arb_if.dma_wdata;
            arb_if.mem_write_enable = arb_if.dma_we;
            streak_d                = '0;
            if (!arb_if.dma_we) begin
              state_d = RD_HOLD;
              owner_d = 1'b1;
              addr_d  = arb_if.dma_addr;
              width_d = arb_if.dma_width;
              sext_d  = arb_if.dma_sign_extend;
            end
          end
        end

        RD_HOLD: begin
          // Keep the load address on the memory while its data returns.
          arb_if.busy            = 1'b1;
          arb_if.mem_width       = width_q;
          arb_if.mem_sign_extend = sext_q;
          arb_if.mem_addr        = addr_q;
          arb_if.mem_data_in     = 32'h0;
          state_d                = IDLE;
          if (owner_q) begin
            arb_if.dma_rvalid = 1'b1;
            arb_if.dma_rdata  = arb_if.mem_data_out;
          end else begin
            arb_if.cpu_rvalid = 1'b1;
            arb_if.cpu_rdata  = arb_if.mem_data_out;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State, streak counter and latched load command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      width_q  <= MEM_BYTE;
      sext_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      sext_q   <= sext_d;
    end
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Bench for d_mem_arbiter: reset checks, a vector table of store
// arbitration, hand-written load/reset sequences and a randomized run
// against a transaction-level reference model.
module tb_d_mem_arbiter;
  import config_pkg::*;

  localparam int unsigned AW        = config_pkg::DMemAddrWidth;
  localparam int unsigned MemBytes  = 1 << AW;
  localparam int unsigned MaxStreak = 4;
  localparam int unsigned NVec      = 20;
  localparam int unsigned NRand     = 2000;

  typedef struct {
    logic        req;
    logic        we;
    mem_width_t  width;
    logic        sext;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    cmd_t        cpu;
    cmd_t        dma;
    logic        e_cg;
    logic        e_dg;
    logic        e_we;
    int unsigned e_addr;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [7:0] mem_arr [MemBytes];
  logic [7:0] ref_arr [MemBytes];
  vec_t       vecs [NVec];

  d_mem_arbiter_if #(.DMemAddrWidth(AW)) bus ();

  d_mem_arbiter #(.DMemAddrWidth(AW), .MaxCoreStreak(MaxStreak)) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned nbytes(input mem_width_t w);
    case (w)
      MEM_BYTE:     return 1;
      MEM_HALFWORD: return 2;
      default:      return 4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input mem_width_t w,
                                         input logic s);
    case (w)
      MEM_BYTE:     return s ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      MEM_HALFWORD: return s ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default:      return raw;
    endcase
  endfunction

  function automatic logic [31:0] mem_raw(input logic [AW-1:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = mem_arr[AW'(a + AW'(i))];
    return r;
  endfunction

  // Single-port memory model: little-endian, addresses wrap, load data
  // appears one cycle after the address.
  always @(posedge clk) begin
    bus.mem_data_out <= extend(mem_raw(bus.mem_addr), bus.mem_width, bus.mem_sign_extend);
    if (bus.mem_write_enable)
      for (int i = 0; i < 4; i++)
        if (i < int'(nbytes(bus.mem_width)))
          mem_arr[AW'(bus.mem_addr + AW'(i))] <= bus.mem_data_in[8*i +: 8];
  end

  function automatic logic [31:0] ref_read(input logic [AW-1:0] a, input mem_width_t w,
                                           input logic s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_arr[AW'(a + AW'(i))];
    return extend(r, w, s);
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input mem_width_t w, input logic [31:0] d);
    for (int i = 0; i < int'(nbytes(w)); i++) ref_arr[AW'(a + AW'(i))] = d[8*i +: 8];
  endtask

  function automatic cmd_t mk(input logic req, input logic we, input mem_width_t w,
                              input logic s, input int unsigned a, input logic [31:0] d);
    cmd_t c;
    c.req = req; c.we = we; c.width = w; c.sext = s; c.addr = AW'(a); c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.req   = 1'b1;
    c.we    = 1'($urandom_range(0, 1));
    c.width = mem_width_t'($urandom_range(0, 2));
    c.sext  = 1'($urandom_range(0, 1));
    c.addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31))
                                          : AW'($urandom_range(0, MemBytes - 1));
    c.wdata = $urandom;
    return c;
  endfunction

  task automatic drive(input cmd_t c, input cmd_t d);
    bus.cpu_req = c.req; bus.cpu_we = c.we; bus.cpu_width = c.width;
    bus.cpu_sign_extend = c.sext; bus.cpu_addr = c.addr; bus.cpu_wdata = c.wdata;
    bus.dma_req = d.req; bus.dma_we = d.we; bus.dma_width = d.width;
    bus.dma_sign_extend = d.sext; bus.dma_addr = d.addr; bus.dma_wdata = d.wdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  cmd_t idle_c;
  cmd_t idle_d;

  initial begin
    cmd_t cc, dc, win;
    bit   ca, da, pend, pend_dma, cw, dw;
    int   streak;
    logic [31:0] pend_data;
    logic [AW-1:0] pend_addr;
    logic e_cg, e_dg, e_cv, e_dv, e_busy, e_we;
    logic [31:0] e_cd, e_dd, e_din;
    logic [AW-1:0] e_addr;

    n_cmp = 0;
    n_err = 0;
    idle_c = mk(0, 0, MEM_WORD, 0, 'h020, 32'h0);
    idle_d = mk(0, 0, MEM_WORD, 0, 'h030, 32'h0);

    // Store-only arbitration table; streak carries from row to row.
    vecs[0] = '{idle_c, idle_d, 1'b0, 1'b0, 1'b0, 'h020};
    vecs[1] = '{mk(1, 1, MEM_WORD, 0, 'h010, 32'hDEADBEEF), idle_d, 1'b1, 1'b0, 1'b1, 'h010};
    vecs[2] = '{mk(0, 0, MEM_WORD, 0, 'h024, 32'h0), mk(1, 1, MEM_WORD, 0, 'h040, 32'h0BADF00D),
                1'b0, 1'b1, 1'b1, 'h040};
    for (int k = 0; k < 10; k++)
      vecs[3+k] = '{mk(1, 1, MEM_WORD, 0, 'h100 + 4*k, 32'hC0000000 + k),
                    mk(1, 1, MEM_WORD, 0, 'h200 + 4*k, 32'hD0000000 + k),
                    (k % 5) != 4, (k % 5) == 4, 1'b1,
                    ((k % 5) == 4) ? 'h200 + 4*k : 'h100 + 4*k};
    vecs[13] = '{mk(1, 1, MEM_WORD, 0, 'h300, 32'h1), mk(1, 1, MEM_WORD, 0, 'h340, 32'h2),
                 1'b1, 1'b0, 1'b1, 'h300};
    vecs[14] = '{mk(1, 1, MEM_WORD, 0, 'h304, 32'h3), idle_d, 1'b1, 1'b0, 1'b1, 'h304};
    for (int k = 0; k < 4; k++)
      vecs[15+k] = '{mk(1, 1, MEM_WORD, 0, 'h308 + 4*k, 32'h4), mk(1, 1, MEM_WORD, 0, 'h348, 32'h5),
                     1'b1, 1'b0, 1'b1, 'h308 + 4*k};
    vecs[19] = '{mk(1, 1, MEM_WORD, 0, 'h318, 32'h6), mk(1, 1, MEM_WORD, 0, 'h34C, 32'h7),
                 1'b0, 1'b1, 1'b1, 'h34C};

    // Reset: a pending cpu store must not be granted while reset is low.
    reset = 1'b0;
    drive(mk(1, 1, MEM_WORD, 0, 'h800, 32'hA5A5A5A5), idle_d);
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("rst_dma_gnt", 32'(bus.dma_gnt), 32'h0);
    chk("rst_we", 32'(bus.mem_write_enable), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_rvalid", {30'h0, bus.cpu_rvalid, bus.dma_rvalid}, 32'h0);
    chk("rst_rdata", bus.cpu_rdata | bus.dma_rdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(bus.cpu_gnt), 32'h1);
    chk("first_grant_we", 32'(bus.mem_write_enable), 32'h1);
    tick();

    for (int v = 0; v < int'(NVec); v++) begin
      drive(vecs[v].cpu, vecs[v].dma);
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_gnt", v), 32'(bus.cpu_gnt), 32'(vecs[v].e_cg));
      chk($sformatf("vec%0d_dma_gnt", v), 32'(bus.dma_gnt), 32'(vecs[v].e_dg));
      chk($sformatf("vec%0d_we", v), 32'(bus.mem_write_enable), 32'(vecs[v].e_we));
      chk($sformatf("vec%0d_addr", v), 32'(bus.mem_addr), vecs[v].e_addr);
      tick();
    end

    // Word load readback; cpu store stays pending through RD_HOLD.
    drive(mk(1, 0, MEM_WORD, 0, 'h010, 32'h0), idle_d);
    @(negedge clk);
    chk("ld_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("ld_we", 32'(bus.mem_write_enable), 32'h0);
    tick();
    drive(mk(1, 1, MEM_BYTE, 0, 'h013, 32'h00000080), idle_d);
    @(negedge clk);
    chk("ld_busy", 32'(bus.busy), 32'h1);
    chk("ld_hold_gnt", 32'(bus.cpu_gnt), 32'h0);
    chk("ld_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    chk("ld_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("ld_dma_rdata", bus.dma_rdata, 32'h0);
    chk("ld_hold_addr", 32'(bus.mem_addr), 32'h010);
    tick();
    @(negedge clk);
    chk("st_after_ld_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("st_after_ld_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("st_after_ld_rdata", bus.cpu_rdata, 32'h0);
    tick();

    // Sign-extended byte load of 0x80.
    drive(mk(1, 0, MEM_BYTE, 1, 'h013, 32'h0), idle_d);
    @(negedge clk);
    chk("sx_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    drive(idle_c, idle_d);
    @(negedge clk);
    chk("sx_busy", 32'(bus.busy), 32'h1);
    chk("sx_rdata", bus.cpu_rdata, 32'hFFFFFF80);
    tick();
    @(negedge clk);
    chk("sx_busy_drop", 32'(bus.busy), 32'h0);
    chk("sx_rvalid_drop", 32'(bus.cpu_rvalid), 32'h0);
    tick();

    // dma load arriving during cpu RD_HOLD waits one cycle.
    drive(mk(1, 0, MEM_WORD, 0, 'h010, 32'h0), idle_d);
    @(negedge clk);
    chk("dq_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    drive(idle_c, mk(1, 0, MEM_BYTE, 0, 'h013, 32'h0));
    @(negedge clk);
    chk("dq_hold_dma_gnt", 32'(bus.dma_gnt), 32'h0);
    chk("dq_cpu_rdata", bus.cpu_rdata, 32'h80ADBEEF);
    tick();
    @(negedge clk);
    chk("dq_dma_gnt", 32'(bus.dma_gnt), 32'h1);
    chk("dq_cpu_rvalid_off", 32'(bus.cpu_rvalid), 32'h0);
    tick();
    drive(idle_c, idle_d);
    @(negedge clk);
    chk("dq_dma_rvalid", 32'(bus.dma_rvalid), 32'h1);
    chk("dq_dma_rdata", bus.dma_rdata, 32'h00000080);
    chk("dq_cpu_rdata_off", bus.cpu_rdata, 32'h0);
    tick();

    // Misaligned word store/load.
    drive(mk(1, 1, MEM_WORD, 0, 'h00E, 32'h11223344), idle_d);
    @(negedge clk);
    chk("mis_st_addr", 32'(bus.mem_addr), 32'h00E);
    chk("mis_st_din", bus.mem_data_in, 32'h11223344);
    tick();
    drive(mk(1, 0, MEM_WORD, 0, 'h00E, 32'h0), idle_d);
    @(negedge clk);
    chk("mis_ld_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    drive(idle_c, idle_d);
    @(negedge clk);
    chk("mis_ld_rdata", bus.cpu_rdata, 32'h11223344);
    tick();

    // Reset in the middle of RD_HOLD drops the load.
    drive(mk(1, 0, MEM_WORD, 0, 'h00E, 32'h0), idle_d);
    @(negedge clk);
    chk("rh_gnt", 32'(bus.cpu_gnt), 32'h1);
    tick();
    drive(mk(1, 1, MEM_WORD, 0, 'h200, 32'h55AA55AA), idle_d);
    chk("rh_busy", 32'(bus.busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rh_busy_rst", 32'(bus.busy), 32'h0);
    chk("rh_rvalid_rst", 32'(bus.cpu_rvalid), 32'h0);
    chk("rh_rdata_rst", bus.cpu_rdata, 32'h0);
    chk("rh_gnt_rst", 32'(bus.cpu_gnt), 32'h0);
    chk("rh_we_rst", 32'(bus.mem_write_enable), 32'h0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rh_post_gnt", 32'(bus.cpu_gnt), 32'h1);
    chk("rh_post_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    tick();
    drive(idle_c, idle_d);
    @(negedge clk);
    chk("rh_post2_rvalid", {30'h0, bus.cpu_rvalid, bus.dma_rvalid}, 32'h0);
    tick();

    // Randomized traffic against the transaction-level model.
    ref_arr = mem_arr;
    streak = 0; pend = 0; pend_dma = 0; pend_data = '0; pend_addr = '0;
    ca = 0; da = 0; cc = idle_c; dc = idle_d;
    for (int n = 0; n < int'(NRand); n++) begin
      if (!ca) begin
        cc = rand_cmd(); cc.req = ($urandom_range(0, 99) < 55); ca = cc.req;
      end
      if (!da) begin
        dc = rand_cmd(); dc.req = ($urandom_range(0, 99) < 45); da = dc.req;
      end
      drive(cc, dc);

      e_cg = 0; e_dg = 0; e_cv = 0; e_dv = 0; e_busy = 0; e_we = 0;
      e_cd = '0; e_dd = '0; e_din = cc.wdata; e_addr = cc.addr;
      cw = 0; dw = 0;
      if (pend) begin
        e_busy = 1; e_addr = pend_addr;
        if (pend_dma) begin e_dv = 1; e_dd = pend_data; end
        else begin e_cv = 1; e_cd = pend_data; end
        pend = 0;
        if (!dc.req) streak = 0;
      end else begin
        cw = cc.req && (!dc.req || streak < int'(MaxStreak));
        dw = dc.req && !cw;
        if (!dc.req || dw) streak = 0;
        else if (cw) streak++;
        if (cw || dw) begin
          win = cw ? cc : dc;
          e_cg = cw; e_dg = dw; e_we = win.we; e_addr = win.addr; e_din = win.wdata;
          if (win.we) ref_write(win.addr, win.width, win.wdata);
          else begin
            pend = 1; pend_dma = dw; pend_addr = win.addr;
            pend_data = ref_read(win.addr, win.width, win.sext);
          end
          if (cw) ca = 0;
          if (dw) da = 0;
        end
      end

      @(negedge clk);
      chk($sformatf("r%0d_cpu_gnt", n), 32'(bus.cpu_gnt), 32'(e_cg));
      chk($sformatf("r%0d_dma_gnt", n), 32'(bus.dma_gnt), 32'(e_dg));
      chk($sformatf("r%0d_cpu_rvalid", n), 32'(bus.cpu_rvalid), 32'(e_cv));
      chk($sformatf("r%0d_dma_rvalid", n), 32'(bus.dma_rvalid), 32'(e_dv));
      chk($sformatf("r%0d_cpu_rdata", n), bus.cpu_rdata, e_cd);
      chk($sformatf("r%0d_dma_rdata", n), bus.dma_rdata, e_dd);
      chk($sformatf("r%0d_busy", n), 32'(bus.busy), 32'(e_busy));
      chk($sformatf("r%0d_we", n), 32'(bus.mem_write_enable), 32'(e_we));
      chk($sformatf("r%0d_addr", n), 32'(bus.mem_addr), 32'(e_addr));
      if (!e_busy) chk($sformatf("r%0d_din", n), bus.mem_data_in, e_din);
      if (cw || dw) chk($sformatf("r%0d_width", n), 32'(bus.mem_width), 32'(win.width));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
